// File: rtl/bf_trivial_pipe.sv
// bf_trivial_pipe: two-stage valid/ready radix-2 butterfly for trivial twiddles.
//   Stage 1 registers s = up + down and d = up - down, each sign-extended to NBITS+1 bits.
//   Stage 2 rotates d by {1, -j, -1, +j}, optionally halves every component,
//   and registers both results.
//
// Optional feature (macro BFJ_ROUND_EN):
//   defined   : scaled component = (x + 1) >>> 1  (round half up)
//   undefined : scaled component = x >>> 1        (truncate toward -inf)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is combinational from out_ready
//   in_up, in_down        {real, imag} operands, NBITS bits per component
//   in_twd                rotation of the difference: 0 x1, 1 x(-j), 2 x(-1), 3 x(+j)
//   in_scale              1 = arithmetic shift right by one on both outputs
//   out_valid / out_ready output handshake
//   out_up, out_down      {real, imag} results, NBITS+1 bits per component
//   grow_sticky           set when an unscaled result needs all NBITS+1 bits
//   grow_clr              synchronous clear of grow_sticky (a same-cycle set wins)
module bf_trivial_pipe #(
  parameter int unsigned NBITS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NBITS-1:0]     in_up,
  input  logic [2*NBITS-1:0]     in_down,
  input  logic [1:0]             in_twd,
  input  logic                   in_scale,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*(NBITS+1)-1:0] out_up,
  output logic [2*(NBITS+1)-1:0] out_down,
  output logic                   grow_sticky,
  input  logic                   grow_clr
);

  localparam int unsigned W1 = NBITS + 1;
  localparam int unsigned W2 = NBITS + 2;

  typedef logic signed [W1-1:0] cmp_t;

  // Halve one component when requested; the extra bit keeps the rounding add exact.
  function automatic cmp_t scale_fn(input cmp_t x, input logic sc);
    logic signed [W2-1:0] ext;
    ext = {x[W1-1], x};
`ifdef BFJ_ROUND_EN
    ext = ext + W2'(1);
`endif
    if (sc) begin
      return W1'(ext >>> 1);
    end
    return x;
  endfunction

  // A component "grows" when its top two bits differ.
  function automatic logic grows_fn(input cmp_t x);
    return x[NBITS] ^ x[NBITS-1];
  endfunction

  // Sign-extended operand components.
  cmp_t up_re, up_im, dn_re, dn_im;

  assign up_re = {in_up[2*NBITS-1],   in_up[2*NBITS-1:NBITS]};
  assign up_im = {in_up[NBITS-1],     in_up[NBITS-1:0]};
  assign dn_re = {in_down[2*NBITS-1], in_down[2*NBITS-1:NBITS]};
  assign dn_im = {in_down[NBITS-1],   in_down[NBITS-1:0]};

  // Stage 1 state.
  logic       s1_valid;
  cmp_t       s1_sr, s1_si, s1_dr, s1_di;
  logic [1:0] s1_twd;
  logic       s1_scale;

  // Stage 2 valid; its data lives directly in out_up / out_down.
  logic s2_valid;

  // Elastic load conditions: each stage loads when empty or when its successor moves.
  logic s2_load_c;
  logic s1_load_c;

  assign s2_load_c = ~s2_valid | out_ready;
  assign s1_load_c = ~s1_valid | s2_load_c;
  assign in_ready  = s1_load_c;
  assign out_valid = s2_valid;

  // Rotated difference and growth detect, both taken from unscaled stage-1 values.
  cmp_t rot_re_c, rot_im_c;
  logic grow_set_c;

  always_comb begin
    rot_re_c = s1_dr;
    rot_im_c = s1_di;
    unique case (s1_twd)
      2'd0: begin rot_re_c =  s1_dr; rot_im_c =  s1_di; end
      2'd1: begin rot_re_c =  s1_di; rot_im_c = -s1_dr; end
      2'd2: begin rot_re_c = -s1_dr; rot_im_c = -s1_di; end
      default: begin rot_re_c = -s1_di; rot_im_c =  s1_dr; end
    endcase
  end

  always_comb begin
    grow_set_c = 1'b0;
    if (s2_load_c && s1_valid && !s1_scale) begin
      grow_set_c = grows_fn(s1_sr) | grows_fn(s1_si) |
                   grows_fn(rot_re_c) | grows_fn(rot_im_c);
    end
  end

  // Stage 1: sum and difference with sideband capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sr    <= '0;
      s1_si    <= '0;
      s1_dr    <= '0;
      s1_di    <= '0;
      s1_twd   <= 2'd0;
      s1_scale <= 1'b0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sr    <= up_re + dn_re;
        s1_si    <= up_im + dn_im;
        s1_dr    <= up_re - dn_re;
        s1_di    <= up_im - dn_im;
        s1_twd   <= in_twd;
        s1_scale <= in_scale;
      end
    end
  end

  // Stage 2: rotation result and optional scaling into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_up   <= '0;
      out_down <= '0;
    end else if (s2_load_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_up   <= {scale_fn(s1_sr, s1_scale), scale_fn(s1_si, s1_scale)};
        out_down <= {scale_fn(rot_re_c, s1_scale), scale_fn(rot_im_c, s1_scale)};
      end
    end
  end

  // Sticky growth flag; a set event in the clear cycle keeps it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grow_sticky <= 1'b0;
    end else if (grow_set_c) begin
      grow_sticky <= 1'b1;
    end else if (grow_clr) begin
      grow_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf_trivial_pipe.sv
module tb_bf_trivial_pipe;

  localparam int unsigned NB = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [2*NB-1:0]     in_up;
  logic [2*NB-1:0]     in_down;
  logic [1:0]          in_twd;
  logic                in_scale;
  logic                out_valid;
  logic                out_ready;
  logic [2*(NB+1)-1:0] out_up;
  logic [2*(NB+1)-1:0] out_down;
  logic                grow_sticky;
  logic                grow_clr;

  bf_trivial_pipe #(.NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_up(in_up), .in_down(in_down), .in_twd(in_twd), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_up(out_up), .out_down(out_down),
    .grow_sticky(grow_sticky), .grow_clr(grow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;

  logic [43:0] sb_q[$];
  bit          hold_vld = 1'b0;
  logic [43:0] hold_val;
  bit          tbl_mode = 1'b0;
  logic [43:0] tbl_exp;

  typedef struct {
    logic [19:0] up;
    logic [19:0] dn;
    logic [1:0]  tw;
    logic        sc;
    logic [21:0] eu;
    logic [21:0] ed;
    logic        eg;
  } vec_t;

  vec_t vt[6];

  function automatic logic [19:0] pk_in(input int re, input int im);
    return {10'(re), 10'(im)};
  endfunction

  function automatic logic [21:0] pk_out(input int re, input int im);
    return {11'(re), 11'(im)};
  endfunction

  function automatic int sx10(input logic [9:0] v);
    logic signed [9:0] t;
    t = v;
    return int'(t);
  endfunction

  // Halving by exact floor division on an even value.
  function automatic int half(input int x);
    int y;
`ifdef BFJ_ROUND_EN
    y = x + 1;
`else
    y = x;
`endif
    return (y - (y & 1)) / 2;
  endfunction

  // Reference butterfly: rotation as a complex multiply by the twiddle.
  function automatic logic [43:0] model(input logic [19:0] u, input logic [19:0] d,
                                        input logic [1:0] tw, input logic sc);
    int ur, ui, dr, di, sr, si, xr, xi, cr, ci, rr, ri;
    ur = sx10(u[19:10]); ui = sx10(u[9:0]);
    dr = sx10(d[19:10]); di = sx10(d[9:0]);
    sr = ur + dr; si = ui + di;
    xr = ur - dr; xi = ui - di;
    case (tw)
      2'd0: begin cr = 1;  ci = 0;  end
      2'd1: begin cr = 0;  ci = -1; end
      2'd2: begin cr = -1; ci = 0;  end
      default: begin cr = 0; ci = 1; end
    endcase
    rr = xr * cr - xi * ci;
    ri = xr * ci + xi * cr;
    if (sc) begin
      sr = half(sr); si = half(si); rr = half(rr); ri = half(ri);
    end
    return {pk_out(sr, si), pk_out(rr, ri)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: observe 1 time unit after the falling edge, then advance to the next falling edge.
  task automatic step(output bit acc, output bit ov);
    logic [43:0] e;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    if (hold_vld && out_valid) chk("stall_hold", 64'({out_up, out_down}), 64'(hold_val));
    hold_vld = 1'b0;
    if (out_valid && !out_ready) begin
      hold_vld = 1'b1;
      hold_val = {out_up, out_down};
    end
    if (out_valid && out_ready) begin
      pops++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %0h expected none", {out_up, out_down});
      end else begin
        e = sb_q.pop_front();
        chk("out_data", 64'({out_up, out_down}), 64'(e));
      end
    end
    if (acc) sb_q.push_back(tbl_mode ? tbl_exp : model(in_up, in_down, in_twd, in_scale));
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, o, saw_block;
    int idx, c, first_block, first_acc, first_out, last_out, drops, p0;
    logic [19:0] iu[16], id[16];
    logic [1:0]  itw[16];
    logic        isc[16];

    vt[0] = '{pk_in(100, 50), pk_in(30, -20), 2'd0, 1'b0, pk_out(130, 30), pk_out(70, 70), 1'b0};
    vt[1] = '{pk_in(100, 50), pk_in(30, -20), 2'd1, 1'b0, pk_out(130, 30), pk_out(70, -70), 1'b0};
    vt[2] = '{pk_in(100, 50), pk_in(30, -20), 2'd2, 1'b0, pk_out(130, 30), pk_out(-70, -70), 1'b0};
    vt[3] = '{pk_in(100, 50), pk_in(30, -20), 2'd3, 1'b0, pk_out(130, 30), pk_out(-70, 70), 1'b0};
`ifdef BFJ_ROUND_EN
    vt[4] = '{pk_in(3, -3), pk_in(0, 0), 2'd0, 1'b1, pk_out(2, -1), pk_out(2, -1), 1'b0};
`else
    vt[4] = '{pk_in(3, -3), pk_in(0, 0), 2'd0, 1'b1, pk_out(1, -2), pk_out(1, -2), 1'b0};
`endif
    vt[5] = '{pk_in(-512, 511), pk_in(-512, -512), 2'd2, 1'b0,
              pk_out(-1024, -1), pk_out(0, -1023), 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_up = '0; in_down = '0; in_twd = 2'd0;
    in_scale = 1'b0; out_ready = 1'b1; grow_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_up", 64'(out_up), 64'(0));
    chk("rst_out_down", 64'(out_down), 64'(0));
    chk("rst_grow", 64'(grow_sticky), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, one at a time, with latency checks.
    tbl_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_up = vt[i].up; in_down = vt[i].dn; in_twd = vt[i].tw; in_scale = vt[i].sc;
      tbl_exp = {vt[i].eu, vt[i].ed};
      in_valid = 1'b1; out_ready = 1'b1;
      step(a, o);
      chk($sformatf("vec%0d_accept", i), 64'(a), 64'(1));
      in_valid = 1'b0;
      step(a, o);
      chk($sformatf("vec%0d_lat1", i), 64'(o), 64'(0));
      step(a, o);
      chk($sformatf("vec%0d_lat2", i), 64'(o), 64'(1));
      chk($sformatf("vec%0d_grow", i), 64'(grow_sticky), 64'(vt[i].eg));
    end
    tbl_mode = 1'b0;
    repeat (3) step(a, o);
    chk("grow_held", 64'(grow_sticky), 64'(1));
    grow_clr = 1'b1;
    step(a, o);
    grow_clr = 1'b0;
    chk("grow_cleared", 64'(grow_sticky), 64'(0));

    for (int i = 0; i < 16; i++) begin
      iu[i] = 20'($urandom); id[i] = 20'($urandom);
      itw[i] = 2'($urandom); isc[i] = 1'($urandom);
    end

    // Back-pressure: out_ready low for cycles 3..7.
    idx = 0; c = 0; saw_block = 1'b0; first_block = -1; p0 = pops;
    while ((idx < 8 || sb_q.size() != 0) && c < 60) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_up = iu[idx]; in_down = id[idx]; in_twd = itw[idx]; in_scale = isc[idx];
      end
      out_ready = !(c >= 3 && c <= 7);
      step(a, o);
      if (in_valid && !a && !saw_block) begin
        saw_block = 1'b1; first_block = c;
      end
      if (a) idx++;
      c++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_blocked", 64'(saw_block), 64'(1));
    chk("bp_first_block", 64'(first_block), 64'(3));
    chk("bp_all_in", 64'(idx), 64'(8));
    chk("bp_all_out", 64'(pops - p0), 64'(8));
    chk("bp_drained", 64'(sb_q.size()), 64'(0));

    // Full-rate streaming.
    idx = 0; c = 0; drops = 0; first_acc = -1; first_out = -1; last_out = -1; p0 = pops;
    out_ready = 1'b1;
    while ((idx < 16 || sb_q.size() != 0) && c < 80) begin
      in_valid = (idx < 16);
      if (idx < 16) begin
        in_up = iu[idx]; in_down = id[idx]; in_twd = itw[idx]; in_scale = isc[idx];
      end
      step(a, o);
      if (in_valid && !a) drops++;
      if (a) begin
        if (first_acc < 0) first_acc = c;
        idx++;
      end
      if (o) begin
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      c++;
    end
    in_valid = 1'b0;
    chk("fr_no_drop", 64'(drops), 64'(0));
    chk("fr_first_lat", 64'(first_out - first_acc), 64'(2));
    chk("fr_back2back", 64'(last_out - first_out), 64'(15));
    chk("fr_all_out", 64'(pops - p0), 64'(16));

    // Reset with two items in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_up = iu[i]; in_down = id[i]; in_twd = itw[i]; in_scale = isc[i];
      step(a, o);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_up", 64'(out_up), 64'(0));
    sb_q.delete();
    hold_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(a, o);
      chk($sformatf("post_rst_idle%0d", i), 64'(o), 64'(0));
    end
    in_valid = 1'b1; in_up = pk_in(-7, 12); in_down = pk_in(5, -300); in_twd = 2'd1; in_scale = 1'b0;
    step(a, o);
    chk("post_rst_accept", 64'(a), 64'(1));
    in_valid = 1'b0;
    step(a, o);
    chk("post_rst_lat1", 64'(o), 64'(0));
    step(a, o);
    chk("post_rst_lat2", 64'(o), 64'(1));
    step(a, o);
    chk("post_rst_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
